// File: rtl/pa_idu_split_sched_pkg.sv
// Shared definitions for the IDU atomic-split issue scheduler:
// split FSM idle code, temp register indices and scheduler state encodings.
package pa_idu_split_sched_pkg;

    localparam int unsigned SCHED_CNT_WIDTH = 3;
    localparam int unsigned SCHED_TMP_NUM   = 2;
    localparam int unsigned IDX_W           = 6;
    localparam int unsigned SPLIT_ST_W      = 3;

    localparam logic [SPLIT_ST_W-1:0] SPLIT_ST_IDLE = 3'b111;
    // Temp register n lives at index TMP_IDX_BASE + n (x32, x33, ...)
    localparam logic [IDX_W-1:0]      TMP_IDX_BASE  = 6'b100000;

    typedef enum logic [1:0] {
        SCHED_S_IDLE   = 2'b00,
        SCHED_S_ACTIVE = 2'b01,
        SCHED_S_DRAIN  = 2'b10
    } sched_st_e;

endpackage

// File: rtl/pa_idu_split_sched.sv
// Issue scheduler for the atomic-split micro-op stream: temp-register scoreboard,
// outstanding micro-op counter and the atomic-inflight flag used by RTU.
module pa_idu_split_sched
    import pa_idu_split_sched_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = SCHED_CNT_WIDTH,
    parameter int unsigned TMP_NUM   = SCHED_TMP_NUM
) (
    input  logic                  idu_misc_cpuclk,
    input  logic                  cpurst_b,
    input  logic [SPLIT_ST_W-1:0] split_sched_st,
    input  logic                  split_sched_uop_vld,
    input  logic                  split_sched_dst_vld,
    input  logic [IDX_W-1:0]      split_sched_dst_idx,
    input  logic [IDX_W-1:0]      split_sched_rs1_idx,
    input  logic                  split_sched_rs2_vld,
    input  logic [IDX_W-1:0]      split_sched_rs2_idx,
    input  logic                  iu_idu_ex1_rdy,
    input  logic                  wb_sched_vld,
    input  logic [IDX_W-1:0]      wb_sched_idx,
    input  logic                  rtu_sched_retire,
    input  logic                  rtu_idu_flush_fe,
    input  logic                  ifu_idu_chgflw_flush,
    output logic                  sched_ctrl_stall,
    output logic                  sched_uop_issue,
    output logic [TMP_NUM-1:0]    sched_tmp_busy,
    output logic                  sched_rtu_atm_inflight
);

    sched_st_e              r_state;
    sched_st_e              w_state_next;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic [TMP_NUM-1:0]     r_tmp_busy;
    logic [TMP_NUM-1:0]     w_tmp_busy_next;
    logic                   r_inflight;

    logic [TMP_NUM-1:0]     w_dst_hit;
    logic [TMP_NUM-1:0]     w_rs1_hit;
    logic [TMP_NUM-1:0]     w_rs2_hit;
    logic [TMP_NUM-1:0]     w_wb_hit;
    logic                   w_flush;
    logic                   w_hazard;
    logic                   w_full;
    logic                   w_issue;
    logic                   w_retire_eff;
    logic                   w_st_idle;

    // Exact index match per temp reg; unused temp indices never hit anything
    always_comb begin
        w_dst_hit = '0;
        w_rs1_hit = '0;
        w_rs2_hit = '0;
        w_wb_hit  = '0;
        for (int unsigned n = 0; n < TMP_NUM; n++) begin
            w_dst_hit[n] = split_sched_dst_vld & (split_sched_dst_idx == TMP_IDX_BASE + IDX_W'(n));
            w_rs1_hit[n] = split_sched_rs1_idx == TMP_IDX_BASE + IDX_W'(n);
            w_rs2_hit[n] = split_sched_rs2_vld & (split_sched_rs2_idx == TMP_IDX_BASE + IDX_W'(n));
            w_wb_hit[n]  = wb_sched_vld & (wb_sched_idx == TMP_IDX_BASE + IDX_W'(n));
        end
    end

    assign w_flush      = rtu_idu_flush_fe | ifu_idu_chgflw_flush;
    // A same-cycle writeback to the pending temp reg bypasses the hazard
    assign w_hazard     = split_sched_uop_vld & (|((w_rs1_hit | w_rs2_hit) & r_tmp_busy & ~w_wb_hit));
    assign w_full       = (r_cnt == {CNT_WIDTH{1'b1}}) & ~rtu_sched_retire;
    assign w_issue      = cpurst_b & split_sched_uop_vld & iu_idu_ex1_rdy & ~w_hazard & ~w_full & ~w_flush;
    assign w_retire_eff = rtu_sched_retire & (r_cnt != '0);
    assign w_st_idle    = split_sched_st == SPLIT_ST_IDLE;

    assign sched_uop_issue        = w_issue;
    assign sched_ctrl_stall       = cpurst_b & split_sched_uop_vld & ~w_issue;
    assign sched_tmp_busy         = r_tmp_busy;
    assign sched_rtu_atm_inflight = r_inflight;

    // Scoreboard and counter next state; set beats clear, flush beats everything
    always_comb begin
        w_tmp_busy_next = (r_tmp_busy & ~w_wb_hit) | (w_issue ? w_dst_hit : '0);
        w_cnt_next      = r_cnt;
        case ({w_issue, w_retire_eff})
            2'b10:   w_cnt_next = r_cnt + CNT_WIDTH'(1);
            2'b01:   w_cnt_next = r_cnt - CNT_WIDTH'(1);
            default: w_cnt_next = r_cnt;
        endcase
        if (w_flush) begin
            w_tmp_busy_next = '0;
            w_cnt_next      = '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCHED_S_IDLE: begin
                if (!w_st_idle) w_state_next = SCHED_S_ACTIVE;
            end
            SCHED_S_ACTIVE: begin
                if (w_st_idle) w_state_next = (w_cnt_next != '0) ? SCHED_S_DRAIN : SCHED_S_IDLE;
            end
            SCHED_S_DRAIN: begin
                if (!w_st_idle)              w_state_next = SCHED_S_ACTIVE;
                else if (w_cnt_next == '0)   w_state_next = SCHED_S_IDLE;
            end
            default: w_state_next = SCHED_S_IDLE;
        endcase
        if (w_flush) w_state_next = SCHED_S_IDLE;
    end

    always_ff @(posedge idu_misc_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state    <= SCHED_S_IDLE;
            r_cnt      <= '0;
            r_tmp_busy <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_tmp_busy <= w_tmp_busy_next;
            r_inflight <= w_state_next != SCHED_S_IDLE;
        end
    end

endmodule

// File: tb/tb_pa_idu_split_sched.sv
// Scoreboard bench for pa_idu_split_sched: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares against the DUT outputs.
module tb_pa_idu_split_sched;

    logic       clk;
    logic       cpurst_b;
    logic [2:0] st;
    logic       vld, dvld, rs2v, rdy, wbv, ret, flush_fe, chgflw;
    logic [5:0] dst, rs1, rs2, wbi;
    logic       stall, issue, infl;
    logic [1:0] busy;

    typedef struct {
        string      nm;
        logic       stall;
        logic       issue;
        logic [1:0] busy;
        logic       infl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [5:0] X32 = 6'd32;
    localparam logic [5:0] X33 = 6'd33;
    localparam logic [5:0] NRM = 6'd5;
    localparam logic [2:0] ACT = 3'b000;
    localparam logic [2:0] IDL = 3'b111;

    pa_idu_split_sched dut (
        .idu_misc_cpuclk        (clk),
        .cpurst_b               (cpurst_b),
        .split_sched_st         (st),
        .split_sched_uop_vld    (vld),
        .split_sched_dst_vld    (dvld),
        .split_sched_dst_idx    (dst),
        .split_sched_rs1_idx    (rs1),
        .split_sched_rs2_vld    (rs2v),
        .split_sched_rs2_idx    (rs2),
        .iu_idu_ex1_rdy         (rdy),
        .wb_sched_vld           (wbv),
        .wb_sched_idx           (wbi),
        .rtu_sched_retire       (ret),
        .rtu_idu_flush_fe       (flush_fe),
        .ifu_idu_chgflw_flush   (chgflw),
        .sched_ctrl_stall       (stall),
        .sched_uop_issue        (issue),
        .sched_tmp_busy         (busy),
        .sched_rtu_atm_inflight (infl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        st = IDL; vld = 0; dvld = 0; rs2v = 0; rdy = 0; wbv = 0; ret = 0;
        flush_fe = 0; chgflw = 0; dst = NRM; rs1 = NRM; rs2 = NRM; wbi = NRM;
    endtask

    // fl[0] = change-flow flush, fl[1] = frontend flush
    task automatic step(input string nm, input logic i_vld, input logic [5:0] i_dst, input logic i_dvld,
                        input logic [5:0] i_rs1, input logic i_rs2v, input logic [5:0] i_rs2,
                        input logic i_rdy, input logic i_wbv, input logic [5:0] i_wbi, input logic i_ret,
                        input logic [2:0] i_st, input logic [1:0] fl,
                        input logic e_stall, input logic e_issue, input logic [1:0] e_busy, input logic e_infl);
        exp_t e;
        @(posedge clk);
        #1;
        vld = i_vld; dst = i_dst; dvld = i_dvld; rs1 = i_rs1; rs2v = i_rs2v; rs2 = i_rs2;
        rdy = i_rdy; wbv = i_wbv; wbi = i_wbi; ret = i_ret; st = i_st;
        chgflw = fl[0]; flush_fe = fl[1];
        e.nm = nm; e.stall = e_stall; e.issue = e_issue; e.busy = e_busy; e.infl = e_infl;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input string field, input logic [1:0] got, input logic [1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s got %0b expected %0b at %0t", nm, field, got, want, $time);
        end
    endtask

    // Monitor: compare every cycle that has a pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "stall", {1'b0, stall}, {1'b0, e.stall});
                chk(e.nm, "issue", {1'b0, issue}, {1'b0, e.issue});
                chk(e.nm, "busy",  busy,          e.busy);
                chk(e.nm, "infl",  {1'b0, infl},  {1'b0, e.infl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        cpurst_b = 1'b0;
        step("rst",        1, X32, 1, NRM, 0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 0, 2'b00, 0);
        @(negedge clk); #1;
        clear_inputs();
        cpurst_b = 1'b1;

        // AMOADD: AMO_LD writes x32, ALU reads x32 -> stall until writeback bypass
        step("amo_ld",     1, X32, 1, NRM,   0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b00, 0);
        step("alu_haz",    1, X33, 1, 6'd6,  1, X32, 1, 0, NRM, 0, ACT, 2'b00, 1, 0, 2'b01, 1);
        step("alu_byp",    1, X33, 1, 6'd6,  1, X32, 1, 1, X32, 0, ACT, 2'b00, 0, 1, 2'b01, 1);
        step("unused_tmp", 1, 6'd34, 1, 6'd34, 0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b10, 1);
        step("rs1_haz",    1, NRM, 0, X33,   0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 1, 0, 2'b10, 1);
        step("wb_x33",     0, NRM, 0, NRM,   0, NRM, 1, 1, X33, 0, ACT, 2'b00, 0, 0, 2'b10, 1);
        // Set/clear collision on x32: set wins
        step("set_x32",    1, X32, 1, NRM,   0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b00, 1);
        step("set_clr",    1, X32, 1, NRM,   0, NRM, 1, 1, X32, 0, ACT, 2'b00, 0, 1, 2'b01, 1);
        step("not_rdy",    1, NRM, 0, NRM,   0, NRM, 0, 0, NRM, 0, ACT, 2'b00, 1, 0, 2'b01, 1);

        // Drain: split FSM idle with cnt=5, retire down to zero
        for (int i = 0; i < 5; i++)
            step("drain",  0, NRM, 0, NRM,   0, NRM, 0, 0, NRM, 1, IDL, 2'b00, 0, 0, 2'b01, 1);
        step("idle_ret0",  0, NRM, 0, NRM,   0, NRM, 0, 0, NRM, 1, IDL, 2'b00, 0, 0, 2'b01, 0);
        step("wb_clr",     0, NRM, 0, NRM,   0, NRM, 0, 1, X32, 0, IDL, 2'b00, 0, 0, 2'b01, 0);

        // Flush mid-AMO with busy=11, cnt=3
        step("q_x32",      1, X32, 1, NRM,   0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b00, 0);
        step("q_x33",      1, X33, 1, NRM,   0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b01, 1);
        step("q_nrm",      1, 6'd7, 1, NRM,  0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b11, 1);
        step("flush_cf",   1, 6'd7, 1, NRM,  0, NRM, 1, 0, NRM, 0, ACT, 2'b01, 1, 0, 2'b11, 1);
        step("post_flush", 0, NRM, 0, NRM,   0, NRM, 0, 0, NRM, 0, IDL, 2'b00, 0, 0, 2'b00, 0);

        // Counter: 7 issues from zero, 8th stalls, retire lets it through
        for (int i = 0; i < 7; i++)
            step("cnt_fill", 1, 6'd7, 0, NRM, 0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b00, (i != 0));
        step("full",       1, 6'd7, 0, NRM,  0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 1, 0, 2'b00, 1);
        step("full_ret",   1, 6'd7, 0, NRM,  0, NRM, 1, 0, NRM, 1, ACT, 2'b00, 0, 1, 2'b00, 1);
        step("still_full", 1, 6'd7, 0, NRM,  0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 1, 0, 2'b00, 1);
        step("flush_fe",   1, 6'd7, 0, NRM,  0, NRM, 1, 0, NRM, 0, ACT, 2'b10, 1, 0, 2'b00, 1);

        // Async reset in the middle of an active sequence
        step("q_x33b",     1, X33, 1, NRM,   0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 1, 2'b00, 0);
        step("rst_mid",    1, X32, 1, NRM,   0, NRM, 1, 0, NRM, 0, ACT, 2'b00, 0, 0, 2'b00, 0);
        cpurst_b = 1'b0;
        @(negedge clk); #1;
        clear_inputs();
        cpurst_b = 1'b1;
        step("post_rst",   0, NRM, 0, NRM,   0, NRM, 0, 0, NRM, 0, IDL, 2'b00, 0, 0, 2'b00, 0);

        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
